car_sprite_render: RTL and testbench



---
 rtl/car_sprite_pkg.sv | 24 ++
 rtl/car_sprite_regs.sv | 83 ++++++++
 rtl/car_sprite_render.sv | 94 +++++++++
 tb/tb_car_sprite_render.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/car_sprite_pkg.sv
// Shared register map, control-field layout and reset constants for the car sprite renderer.
package car_sprite_pkg;

   typedef enum logic [1:0] {
      REG_X      = 2'd0,
      REG_Y      = 2'd1,
      REG_CTRL   = 2'd2,
      REG_CHROMA = 2'd3
   } reg_sel_e;

   localparam int SPR_DIM = 32;
   localparam logic [11:0] DEFAULT_CHROMA = 12'hF0F;

   localparam int CTRL_ENABLE = 0;
   localparam int CTRL_MIRROR = 1;
   localparam int CTRL_BLINK  = 2;

   typedef struct packed {
      logic blink_en;
      logic mirror;
      logic enable;
   } ctrl_t;

endpackage

// File: rtl/car_sprite_regs.sv
// Shadow/active sprite registers committed on frame_start, plus the 6-bit blink counter.
// Writes are accepted every cycle; there is no backpressure on the register port.
module car_sprite_regs
   import car_sprite_pkg::*;
#(
   parameter int CD = 12,
   parameter int XW = 11,
   parameter int YW = 11
)(
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_frame_start,
   input  logic          i_wr_en,
   input  logic [1:0]    i_wr_addr,
   input  logic [15:0]   i_wr_data,
   output logic [XW-1:0] o_x_pos,
   output logic [YW-1:0] o_y_pos,
   output logic          o_mirror,
   output logic          o_enable,
   output logic          o_hide,
   output logic [CD-1:0] o_chroma
);

   logic [XW-1:0] r_sh_x;
   logic [YW-1:0] r_sh_y;
   ctrl_t         r_sh_ctrl;
   logic [CD-1:0] r_sh_chroma;

   logic [XW-1:0] r_act_x;
   logic [YW-1:0] r_act_y;
   ctrl_t         r_act_ctrl;
   logic [CD-1:0] r_act_chroma;

   logic [5:0]    r_blink_cnt;
   logic          w_unused_wr_bits;

   assign w_unused_wr_bits = &{1'b0, i_wr_data};

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_sh_x      <= '0;
         r_sh_y      <= '0;
         r_sh_ctrl   <= '0;
         r_sh_chroma <= CD'(DEFAULT_CHROMA);
      end else if (i_wr_en) begin
         case (i_wr_addr)
            REG_X:      r_sh_x      <= i_wr_data[XW-1:0];
            REG_Y:      r_sh_y      <= i_wr_data[YW-1:0];
            REG_CTRL:   r_sh_ctrl   <= '{blink_en: i_wr_data[CTRL_BLINK],
                                         mirror:   i_wr_data[CTRL_MIRROR],
                                         enable:   i_wr_data[CTRL_ENABLE]};
            REG_CHROMA: r_sh_chroma <= i_wr_data[CD-1:0];
            default: ;
         endcase
      end
   end

   // Active copies sample the shadow before this edge's write lands, so a
   // write coinciding with frame_start waits for the following frame.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_act_x      <= '0;
         r_act_y      <= '0;
         r_act_ctrl   <= '0;
         r_act_chroma <= CD'(DEFAULT_CHROMA);
         r_blink_cnt  <= '0;
      end else if (i_frame_start) begin
         r_act_x      <= r_sh_x;
         r_act_y      <= r_sh_y;
         r_act_ctrl   <= r_sh_ctrl;
         r_act_chroma <= r_sh_chroma;
         r_blink_cnt  <= r_blink_cnt + 6'd1;
      end
   end

   assign o_x_pos  = r_act_x;
   assign o_y_pos  = r_act_y;
   assign o_mirror = r_act_ctrl.mirror;
   assign o_enable = r_act_ctrl.enable;
   assign o_hide   = r_act_ctrl.blink_en & r_blink_cnt[5];
   assign o_chroma = r_act_chroma;

endmodule

// File: rtl/car_sprite_render.sv
// Car sprite renderer: pixel x/y in cycle n -> sprite colour/hit valid in cycle n+2.
// Fixed pipeline, one pixel per clock, never stalls and applies no backpressure.
module car_sprite_render
   import car_sprite_pkg::*;
#(
   parameter int CD       = 12,
   parameter int SPR_BITS = 5,
   parameter int XW       = 11,
   parameter int YW       = 11
)(
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic [XW-1:0]         i_x,
   input  logic [YW-1:0]         i_y,
   input  logic                  i_frame_start,
   input  logic                  i_wr_en,
   input  logic [1:0]            i_wr_addr,
   input  logic [15:0]           i_wr_data,
   output logic [2*SPR_BITS-1:0] o_ram_addr,
   input  logic [CD-1:0]         i_ram_dout,
   output logic [CD-1:0]         o_spr_rgb,
   output logic                  o_spr_hit
);

   logic [XW-1:0]         w_x_pos;
   logic [YW-1:0]         w_y_pos;
   logic                  w_mirror;
   logic                  w_enable;
   logic                  w_hide;
   logic [CD-1:0]         w_chroma;

   logic [XW:0]           w_dx;
   logic [YW:0]           w_dy;
   logic                  w_in_box;
   logic [SPR_BITS-1:0]   w_col;
   logic [2*SPR_BITS-1:0] w_ram_addr;
   logic                  w_hit;

   logic [2*SPR_BITS-1:0] r_addr_hold;
   logic                  r_vis;
   logic                  r_spr_hit;
   logic [CD-1:0]         r_spr_rgb;

   car_sprite_regs #(
      .CD (CD),
      .XW (XW),
      .YW (YW)
   ) u_regs (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_frame_start (i_frame_start),
      .i_wr_en       (i_wr_en),
      .i_wr_addr     (i_wr_addr),
      .i_wr_data     (i_wr_data),
      .o_x_pos       (w_x_pos),
      .o_y_pos       (w_y_pos),
      .o_mirror      (w_mirror),
      .o_enable      (w_enable),
      .o_hide        (w_hide),
      .o_chroma      (w_chroma)
   );

   // Top bit of each difference is its sign; the box test is "all bits above
   // the sprite index are zero", which also rejects negative and wrapped offsets.
   assign w_dx     = {1'b0, i_x} - {1'b0, w_x_pos};
   assign w_dy     = {1'b0, i_y} - {1'b0, w_y_pos};
   assign w_in_box = (w_dx[XW:SPR_BITS] == '0) && (w_dy[YW:SPR_BITS] == '0);

   assign w_col      = w_mirror ? ~w_dx[SPR_BITS-1:0] : w_dx[SPR_BITS-1:0];
   assign w_ram_addr = i_reset  ? '0
                     : w_in_box ? {w_dy[SPR_BITS-1:0], w_col}
                     :            r_addr_hold;
   assign o_ram_addr = w_ram_addr;

   assign w_hit = r_vis & (i_ram_dout != w_chroma);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_addr_hold <= '0;
         r_vis       <= 1'b0;
         r_spr_hit   <= 1'b0;
         r_spr_rgb   <= '0;
      end else begin
         r_addr_hold <= w_ram_addr;
         r_vis       <= w_in_box & w_enable & ~w_hide;
         r_spr_hit   <= w_hit;
         r_spr_rgb   <= w_hit ? i_ram_dout : '0;
      end
   end

   assign o_spr_hit = r_spr_hit;
   assign o_spr_rgb = r_spr_rgb;

endmodule

// File: tb/tb_car_sprite_render.sv
// Bench for car_sprite_render: behavioural sprite RAM, register/blink model and a pixel scoreboard.
module tb_car_sprite_render;

   logic        clk = 1'b0;
   logic        rst;
   logic [10:0] x, y;
   logic        fs, we;
   logic [1:0]  wa;
   logic [15:0] wd;
   logic [9:0]  ram_addr;
   logic [11:0] ram_dout = 12'h000;
   logic [11:0] spr_rgb;
   logic        spr_hit;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct packed {
      logic        chk;
      logic        hit;
      logic [11:0] rgb;
   } exp_t;
   exp_t sb[$];

   logic [10:0] a_x, s_x, a_y, s_y;
   logic [2:0]  a_ctrl, s_ctrl;
   logic [11:0] a_chr, s_chr;
   logic [5:0]  m_cnt;
   logic [9:0]  m_hold;

   always #5 clk = ~clk;

   car_sprite_render dut (
      .i_clk         (clk),
      .i_reset       (rst),
      .i_x           (x),
      .i_y           (y),
      .i_frame_start (fs),
      .i_wr_en       (we),
      .i_wr_addr     (wa),
      .i_wr_data     (wd),
      .o_ram_addr    (ram_addr),
      .i_ram_dout    (ram_dout),
      .o_spr_rgb     (spr_rgb),
      .o_spr_hit     (spr_hit)
   );

   // Sprite image: address 5 is painted in the default key colour.
   function automatic logic [11:0] rom_val(input logic [9:0] a);
      if (a == 10'd5) return 12'hF0F;
      return {2'b01, a};
   endfunction

   always @(posedge clk) ram_dout <= rom_val(ram_addr);

   task automatic model_reset();
      a_x = 0; s_x = 0; a_y = 0; s_y = 0;
      a_ctrl = 0; s_ctrl = 0;
      a_chr = 12'hF0F; s_chr = 12'hF0F;
      m_cnt = 0; m_hold = 0;
      sb.delete();
   endtask

   // One clock of stimulus; pushes the expected pixel and retires the one from two cycles ago.
   task automatic cycle(input logic [10:0] px, input logic [10:0] py, input logic pfs,
                        input logic pwe, input logic [1:0] pwa, input logic [15:0] pwd,
                        input logic chk, input logic chk_addr);
      int dxi, dyi, col;
      logic inb, vis;
      logic [9:0] ea;
      logic [11:0] pix;
      exp_t e;
      @(posedge clk); #1;
      x = px; y = py; fs = pfs; we = pwe; wa = pwa; wd = pwd;
      dxi = int'(px) - int'(a_x);
      dyi = int'(py) - int'(a_y);
      inb = (dxi >= 0) && (dxi < 32) && (dyi >= 0) && (dyi < 32);
      col = a_ctrl[1] ? (31 - dxi) : dxi;
      ea  = inb ? 10'(dyi * 32 + col) : m_hold;
      vis = inb && a_ctrl[0] && !(a_ctrl[2] && m_cnt[5]);
      pix = rom_val(ea);
      e.chk = chk && !pfs && !rst;
      e.hit = vis && (pix != a_chr);
      e.rgb = e.hit ? pix : 12'h000;
      sb.push_back(e);
      m_hold = rst ? 10'd0 : ea;
      if (pfs) begin
         a_x = s_x; a_y = s_y; a_ctrl = s_ctrl; a_chr = s_chr;
         m_cnt = m_cnt + 6'd1;
      end
      if (pwe) begin
         case (pwa)
            2'd0: s_x = pwd[10:0];
            2'd1: s_y = pwd[10:0];
            2'd2: s_ctrl = pwd[2:0];
            default: s_chr = pwd[11:0];
         endcase
      end
      @(negedge clk);
      if (chk_addr && !rst) begin
         n_total++;
         if (ram_addr !== ea)
            $display("FAIL ram_addr x=%0d y=%0d: got %0d want %0d", px, py, ram_addr, ea);
         else n_pass++;
      end
      if (sb.size() > 2) begin
         e = sb.pop_front();
         if (e.chk) begin
            n_total++;
            if (spr_hit !== e.hit || spr_rgb !== e.rgb)
               $display("FAIL pixel @%0t: got hit=%b rgb=%h want hit=%b rgb=%h",
                        $time, spr_hit, spr_rgb, e.hit, e.rgb);
            else n_pass++;
         end
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [15:0] d);
      cycle(11'd2047, 11'd2047, 1'b0, 1'b1, a, d, 1'b1, 1'b0);
   endtask
   task automatic frame();
      cycle(11'd2047, 11'd2047, 1'b1, 1'b0, 2'd0, 16'd0, 1'b1, 1'b0);
   endtask
   task automatic pix(input logic [10:0] px, input logic [10:0] py);
      cycle(px, py, 1'b0, 1'b0, 2'd0, 16'd0, 1'b1, 1'b1);
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(11'd2047, 11'd2047, 1'b0, 1'b0, 2'd0, 16'd0, 1'b1, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      idle(2);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; x = 0; y = 0; fs = 0; we = 0; wa = 0; wd = 0;
      model_reset();
      repeat (3) @(negedge clk);
      n_total++; if (spr_hit !== 1'b0) $display("FAIL reset_hit: got %b want 0", spr_hit); else n_pass++;
      n_total++; if (spr_rgb !== 12'h000) $display("FAIL reset_rgb: got %h want 000", spr_rgb); else n_pass++;
      n_total++; if (ram_addr !== 10'd0) $display("FAIL reset_addr: got %0d want 0", ram_addr); else n_pass++;
      rst = 1'b0;
      idle(2);
   endtask

   task automatic test_shadow_only();
      wr(2'd0, 16'd100); wr(2'd1, 16'd50); wr(2'd2, 16'd1);
      for (int i = 0; i < 32; i++) pix(11'(100 + i), 11'd50);
      idle(2);
      n_total++; if (spr_hit !== 1'b0) $display("FAIL shadow_only_hit: got %b want 0", spr_hit); else n_pass++;
   endtask

   task automatic test_commit_sweep();
      frame();
      for (int i = 0; i < 32; i++) begin
         pix(11'(100 + i), 11'd50);
         n_total++;
         if (ram_addr !== 10'(i)) $display("FAIL sweep_addr: got %0d want %0d", ram_addr, i);
         else n_pass++;
      end
      idle(2);
   endtask

   task automatic test_mirror();
      wr(2'd2, 16'd3); frame();
      pix(11'd100, 11'd51);
      n_total++; if (ram_addr !== 10'd63) $display("FAIL mirror_left: got %0d want 63", ram_addr); else n_pass++;
      pix(11'd131, 11'd51);
      n_total++; if (ram_addr !== 10'd32) $display("FAIL mirror_right: got %0d want 32", ram_addr); else n_pass++;
      idle(2);
   endtask

   task automatic test_chroma();
      wr(2'd2, 16'd1); frame();
      pix(11'd105, 11'd50); idle(2);
      n_total++;
      if (spr_hit !== 1'b0 || spr_rgb !== 12'h000)
         $display("FAIL chroma_keyed: got hit=%b rgb=%h want hit=0 rgb=000", spr_hit, spr_rgb);
      else n_pass++;
      wr(2'd3, 16'h0000); frame();
      pix(11'd105, 11'd50); idle(2);
      n_total++;
      if (spr_hit !== 1'b1 || spr_rgb !== 12'hF0F)
         $display("FAIL chroma_changed: got hit=%b rgb=%h want hit=1 rgb=f0f", spr_hit, spr_rgb);
      else n_pass++;
   endtask

   task automatic test_wrap();
      wr(2'd0, 16'd2040); frame();
      pix(11'd5, 11'd50); idle(2);
      n_total++; if (spr_hit !== 1'b0) $display("FAIL wrap_hit: got %b want 0", spr_hit); else n_pass++;
      wr(2'd0, 16'd620); frame();
      pix(11'd639, 11'd50);
      n_total++; if (ram_addr !== 10'd19) $display("FAIL edge_addr: got %0d want 19", ram_addr); else n_pass++;
      idle(2);
      n_total++;
      if (spr_hit !== 1'b1 || spr_rgb !== 12'h413)
         $display("FAIL edge_hit: got hit=%b rgb=%h want hit=1 rgb=413", spr_hit, spr_rgb);
      else n_pass++;
   endtask

   task automatic test_same_cycle_commit();
      wr(2'd0, 16'd100); frame();
      cycle(11'd2047, 11'd2047, 1'b1, 1'b1, 2'd0, 16'd200, 1'b1, 1'b0);
      pix(11'd100, 11'd50); idle(2);
      n_total++; if (spr_hit !== 1'b1) $display("FAIL same_cycle_old_pos: got %b want 1", spr_hit); else n_pass++;
      pix(11'd200, 11'd50); idle(2);
      n_total++; if (spr_hit !== 1'b0) $display("FAIL same_cycle_new_early: got %b want 0", spr_hit); else n_pass++;
      frame();
      pix(11'd200, 11'd50); idle(2);
      n_total++; if (spr_hit !== 1'b1) $display("FAIL next_frame_new_pos: got %b want 1", spr_hit); else n_pass++;
      pix(11'd100, 11'd50); idle(2);
      n_total++; if (spr_hit !== 1'b0) $display("FAIL next_frame_old_pos: got %b want 0", spr_hit); else n_pass++;
   endtask

   task automatic test_blink();
      logic want;
      do_reset();
      wr(2'd0, 16'd100); wr(2'd1, 16'd50); wr(2'd2, 16'd5);
      for (int k = 1; k <= 66; k++) begin
         frame();
         pix(11'd110, 11'd50); idle(2);
         want = ((k % 64) < 32);
         n_total++;
         if (spr_hit !== want) $display("FAIL blink_frame%0d: got %b want %b", k, spr_hit, want);
         else n_pass++;
      end
   endtask

   task automatic test_mid_reset();
      repeat (3) pix(11'd110, 11'd50);
      n_total++; if (spr_hit !== 1'b1) $display("FAIL pre_reset_hit: got %b want 1", spr_hit); else n_pass++;
      #1 rst = 1'b1;
      #1;
      n_total++;
      if (spr_hit !== 1'b0 || spr_rgb !== 12'h000)
         $display("FAIL async_reset_out: got hit=%b rgb=%h want 0/000", spr_hit, spr_rgb);
      else n_pass++;
      model_reset();
      repeat (2) pix(11'd110, 11'd50);
      rst = 1'b0;
      frame();
      pix(11'd10, 11'd10); idle(2);
      n_total++; if (spr_hit !== 1'b0) $display("FAIL post_reset_disabled: got %b want 0", spr_hit); else n_pass++;
      wr(2'd2, 16'd1);
      pix(11'd10, 11'd10); idle(2);
      n_total++; if (spr_hit !== 1'b0) $display("FAIL post_reset_uncommitted: got %b want 0", spr_hit); else n_pass++;
      frame();
      pix(11'd10, 11'd10); idle(2);
      n_total++;
      if (spr_hit !== 1'b1 || spr_rgb !== rom_val(10'd330))
         $display("FAIL post_reset_reenabled: got hit=%b rgb=%h want 1/%h", spr_hit, spr_rgb, rom_val(10'd330));
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_shadow_only();
      test_commit_sweep();
      test_mirror();
      test_chroma();
      test_wrap();
      test_same_cycle_commit();
      test_blink();
      test_mid_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1);
   end

endmodule
